// File: rtl/writeback_stage_pkg.sv
// Shared writeback types: load-size encoding and the buffered result entry.
package writeback_stage_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     ins;
        logic [4:0]      rd;
        logic            reg_w;
        logic            is_csr;
        logic [XLEN-1:0] rd_data;
        logic [XLEN-1:0] csr_data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_load_data_formatter.sv
// Extracts the addressed load field from an 8-byte-aligned word and sign/zero-extends it.
module load_data_formatter
    import writeback_stage_pkg::*;
(
    input  msize_t      msize,
    input  logic        sig,
    input  logic [2:0]  offset,
    input  logic [63:0] raw,
    output logic [63:0] data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = raw >> {offset, 3'b000};
        data    = shifted;
        // sig=1 selects zero-extension (ins[14] of the unsigned load forms)
        case (msize)
            MSIZE1:  data = sig ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            MSIZE2:  data = sig ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            MSIZE4:  data = sig ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: buffers completed instructions and commits one per cycle from the head.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [63:0]      mem_pc,
    input  logic [31:0]      mem_ins,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_w,
    input  logic             mem_mem_to_reg,
    input  logic             mem_is_csr,
    input  logic [2:0]       mem_msize,
    input  logic             mem_sig,
    input  logic [63:0]      mem_alu_result,
    input  logic [63:0]      mem_load_data,
    input  logic [63:0]      mem_csr_old,
    input  logic [63:0]      mem_csr_new,
    input  logic             commit_stall,
    output logic             w_en,
    output logic [4:0]       reg_writeback_rd,
    output logic [63:0]      reg_writeback_data,
    output logic             csr_w_en,
    output logic [63:0]      reg_writeback_csr_data_out,
    output logic             commit_valid,
    output logic [63:0]      commit_pc,
    output logic [31:0]      commit_ins,
    output logic [CNT_W-1:0] minstret
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_entry_t         buf_q [DEPTH];
    wb_entry_t         buf_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  minstret_q, minstret_d;

    logic [63:0]       load_fmt;
    wb_entry_t         new_entry;
    wb_entry_t         head;
    logic              have, fire, enq;

    load_data_formatter u_fmt (
        .msize  (msize_t'(mem_msize)),
        .sig    (mem_sig),
        .offset (mem_alu_result[2:0]),
        .raw    (mem_load_data),
        .data   (load_fmt)
    );

    always_comb begin
        new_entry          = '0;
        new_entry.pc       = mem_pc;
        new_entry.ins      = mem_ins;
        new_entry.rd       = mem_rd;
        new_entry.reg_w    = mem_reg_w;
        new_entry.is_csr   = mem_is_csr;
        new_entry.csr_data = mem_csr_new;
        if (mem_is_csr)          new_entry.rd_data = mem_csr_old;
        else if (mem_mem_to_reg) new_entry.rd_data = load_fmt;
        else                     new_entry.rd_data = mem_alu_result;
        // x0 writes still pulse w_en for the scoreboard, but carry zero data
        if (mem_rd == 5'd0)      new_entry.rd_data = '0;
    end

    always_comb begin
        head      = buf_q[head_q];
        have      = (count_q != '0);
        fire      = have && !commit_stall;
        // ready comes from registered count only; the async reset also forces it low
        mem_ready = (count_q < CW'(DEPTH)) && !rst;
        enq       = mem_valid && mem_ready;

        buf_d = buf_q;
        if (enq) buf_d[tail_q] = new_entry;
        head_d     = head_q + PW'(fire);
        tail_d     = tail_q + PW'(enq);
        count_d    = count_q + CW'(enq) - CW'(fire);
        minstret_d = minstret_q + CNT_W'(fire);

        commit_valid               = fire;
        w_en                       = fire && head.reg_w;
        csr_w_en                   = fire && head.is_csr;
        reg_writeback_rd           = have ? head.rd       : '0;
        reg_writeback_data         = have ? head.rd_data  : '0;
        reg_writeback_csr_data_out = have ? head.csr_data : '0;
        commit_pc                  = have ? head.pc       : '0;
        commit_ins                 = have ? head.ins      : '0;
        minstret                   = minstret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            minstret_q <= '0;
        end else begin
            buf_q      <= buf_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a randomized run against a queue model.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0, mem_ready;
    logic [63:0] mem_pc = '0, mem_alu_result = '0, mem_load_data = '0;
    logic [63:0] mem_csr_old = '0, mem_csr_new = '0;
    logic [31:0] mem_ins = '0;
    logic [4:0]  mem_rd = '0;
    logic        mem_reg_w = 1'b0, mem_mem_to_reg = 1'b0, mem_is_csr = 1'b0, mem_sig = 1'b0;
    logic [2:0]  mem_msize = '0;
    logic        commit_stall = 1'b0;
    logic        w_en, csr_w_en, commit_valid;
    logic [4:0]  reg_writeback_rd;
    logic [63:0] reg_writeback_data, reg_writeback_csr_data_out, commit_pc;
    logic [31:0] commit_ins;
    logic [63:0] minstret;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic [4:0]  rd;
        logic        reg_w;
        logic        is_csr;
        logic [63:0] data;
        logic [63:0] csr;
    } ref_t;

    ref_t        q[$];
    logic [63:0] m_minstret = '0;

    writeback_stage #(.DEPTH(DEPTH), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_pc(mem_pc), .mem_ins(mem_ins), .mem_rd(mem_rd), .mem_reg_w(mem_reg_w),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_is_csr(mem_is_csr), .mem_msize(mem_msize),
        .mem_sig(mem_sig), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .mem_csr_old(mem_csr_old), .mem_csr_new(mem_csr_new), .commit_stall(commit_stall),
        .w_en(w_en), .reg_writeback_rd(reg_writeback_rd), .reg_writeback_data(reg_writeback_data),
        .csr_w_en(csr_w_en), .reg_writeback_csr_data_out(reg_writeback_csr_data_out),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_ins(commit_ins),
        .minstret(minstret)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && mem_valid && !mem_ready)
            $error("protocol: mem_valid pulsed while mem_ready=0");
    end

    // Load field extraction from the access size in bytes, independent of the RTL's case split
    function automatic logic [63:0] fmt(logic [2:0] msz, logic sig, logic [2:0] off, logic [63:0] raw);
        int unsigned bits;
        logic [63:0] v, mask;
        bits = 8 << msz;
        v = raw >> (off * 8);
        if (bits >= 64) return v;
        mask = (64'd1 << bits) - 64'd1;
        v = v & mask;
        if (!sig && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic ref_t build();
        ref_t e;
        e.pc = mem_pc; e.ins = mem_ins; e.rd = mem_rd; e.reg_w = mem_reg_w;
        e.is_csr = mem_is_csr; e.csr = mem_csr_new;
        if (mem_is_csr) e.data = mem_csr_old;
        else if (mem_mem_to_reg) e.data = fmt(mem_msize, mem_sig, mem_alu_result[2:0], mem_load_data);
        else e.data = mem_alu_result;
        if (mem_rd == 0) e.data = 0;
        return e;
    endfunction

    task automatic send(input logic [4:0] rd, input logic reg_w, input logic m2r, input logic csr,
                        input logic [2:0] msz, input logic sig, input logic [63:0] alu,
                        input logic [63:0] ld, input logic [63:0] cold, input logic [63:0] cnew);
        mem_valid = 1'b1; mem_pc = {$urandom, $urandom}; mem_ins = $urandom;
        mem_rd = rd; mem_reg_w = reg_w; mem_mem_to_reg = m2r; mem_is_csr = csr;
        mem_msize = msz; mem_sig = sig; mem_alu_result = alu; mem_load_data = ld;
        mem_csr_old = cold; mem_csr_new = cnew;
    endtask

    // Advances one clock edge and updates the model with what the edge should do
    task automatic tick();
        bit   exp_ready, fire;
        ref_t e;
        exp_ready = (q.size() < DEPTH);
        fire = (q.size() > 0) && !commit_stall;
        e = build();
        @(posedge clk);
        if (rst) begin
            q.delete(); m_minstret = 0;
        end else begin
            if (fire) begin void'(q.pop_front()); m_minstret++; end
            if (mem_valid && exp_ready) q.push_back(e);
        end
        #1 mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (commit_valid !== 0 || w_en !== 0 || csr_w_en !== 0) begin bad++;
            $display("FAIL reset_pulses cv=%b w=%b csr=%b required 0", commit_valid, w_en, csr_w_en); end
        total++; if (reg_writeback_data !== 0 || reg_writeback_rd !== 0 || minstret !== 0 || commit_pc !== 0) begin bad++;
            $display("FAIL reset_values data=%h rd=%0d minstret=%0d pc=%h required 0", reg_writeback_data, reg_writeback_rd, minstret, commit_pc); end
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_during got=%b required 0", mem_ready); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b required 1", mem_ready); end
    endtask

    task automatic test_addi();
        send(5'd5, 1, 0, 0, 3'd3, 0, 64'h2A, 0, 0, 0);
        tick();
        #1;
        total++; if (commit_valid !== 1 || w_en !== 1 || reg_writeback_rd !== 5 || reg_writeback_data !== 64'h2A) begin bad++;
            $display("FAIL addi cv=%b w=%b rd=%0d data=%h required 1 1 5 2a", commit_valid, w_en, reg_writeback_rd, reg_writeback_data); end
        tick();
        total++; if (minstret !== 64'd1) begin bad++; $display("FAIL addi_minstret got=%0d required 1", minstret); end
    endtask

    task automatic test_loads();
        send(5'd6, 1, 1, 0, MSIZE1, 0, 64'h1003, 64'h00000000_80FF0000, 0, 0);
        tick();
        #1;
        total++; if (reg_writeback_data !== 64'hFFFFFFFF_FFFFFF80 || w_en !== 1) begin bad++;
            $display("FAIL lb data=%h w=%b required ffffffffffffff80 1", reg_writeback_data, w_en); end
        send(5'd7, 1, 1, 0, MSIZE2, 1, 64'h1006, 64'h8001_0000_0000_0000, 0, 0);
        tick();
        #1;
        total++; if (reg_writeback_data !== 64'h0000_0000_0000_8001 || reg_writeback_rd !== 7) begin bad++;
            $display("FAIL lhu data=%h rd=%0d required 8001 7", reg_writeback_data, reg_writeback_rd); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] w_rd [2];
        int wcount;
        commit_stall = 1'b1;
        send(5'd10, 1, 0, 0, 3'd3, 0, 64'h111, 0, 0, 0); tick();
        send(5'd11, 1, 0, 0, 3'd3, 0, 64'h222, 0, 0, 0); tick();
        #1;
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL stall_full_ready got=%b required 0", mem_ready); end
        total++; if (commit_valid !== 0 || w_en !== 0 || reg_writeback_rd !== 10 || reg_writeback_data !== 64'h111) begin bad++;
            $display("FAIL stall_hold cv=%b w=%b rd=%0d data=%h required 0 0 10 111", commit_valid, w_en, reg_writeback_rd, reg_writeback_data); end
        commit_stall = 1'b0;
        #1;
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL full_commit_ready got=%b required 0", mem_ready); end
        wcount = 0;
        for (int i = 0; i < 4; i++) begin
            if (w_en === 1'b1) begin
                if (wcount < 2) w_rd[wcount] = reg_writeback_rd;
                wcount++;
            end
            tick();
            #1;
        end
        total++; if (wcount !== 2) begin bad++; $display("FAIL drain_wen_count got=%0d required 2", wcount); end
        total++; if (wcount >= 2 && (w_rd[0] !== 10 || w_rd[1] !== 11)) begin bad++;
            $display("FAIL drain_order got=%0d,%0d required 10,11", w_rd[0], w_rd[1]); end
        send(5'd12, 1, 0, 0, 3'd3, 0, 64'h333, 0, 0, 0); tick();
        #1;
        total++; if (reg_writeback_rd !== 12 || w_en !== 1) begin bad++;
            $display("FAIL third_pulse rd=%0d w=%b required 12 1", reg_writeback_rd, w_en); end
        tick();
    endtask

    task automatic test_x0();
        send(5'd0, 1, 0, 0, 3'd3, 0, 64'h55, 0, 0, 0);
        tick();
        #1;
        total++; if (w_en !== 1 || reg_writeback_rd !== 0 || reg_writeback_data !== 0) begin bad++;
            $display("FAIL x0 w=%b rd=%0d data=%h required 1 0 0", w_en, reg_writeback_rd, reg_writeback_data); end
        tick();
    endtask

    task automatic test_csr();
        send(5'd8, 1, 0, 1, 3'd3, 0, 64'hDEAD, 0, 64'h1800, 64'h8);
        tick();
        #1;
        total++; if (w_en !== 1 || reg_writeback_data !== 64'h1800 || csr_w_en !== 1 || reg_writeback_csr_data_out !== 64'h8) begin bad++;
            $display("FAIL csrrw w=%b data=%h csr_w=%b csr=%h required 1 1800 1 8", w_en, reg_writeback_data, csr_w_en, reg_writeback_csr_data_out); end
        tick();
    endtask

    task automatic test_async_reset();
        int wcount;
        commit_stall = 1'b1;
        send(5'd3, 1, 0, 0, 3'd3, 0, 64'h1, 0, 0, 0); tick();
        send(5'd4, 1, 0, 0, 3'd3, 0, 64'h2, 0, 0, 0); tick();
        #2 rst = 1'b1;
        #1;
        total++; if (commit_valid !== 0 || w_en !== 0 || reg_writeback_rd !== 0 || reg_writeback_data !== 0 || mem_ready !== 0) begin bad++;
            $display("FAIL async_rst cv=%b w=%b rd=%0d data=%h ready=%b required all 0", commit_valid, w_en, reg_writeback_rd, reg_writeback_data, mem_ready); end
        total++; if (minstret !== 0) begin bad++; $display("FAIL async_rst_minstret got=%0d required 0", minstret); end
        q.delete(); m_minstret = 0;
        #1 rst = 1'b0;
        commit_stall = 1'b0;
        wcount = 0;
        for (int i = 0; i < 4; i++) begin
            #1 if (w_en === 1'b1 || commit_valid === 1'b1) wcount++;
            tick();
        end
        total++; if (wcount !== 0 || minstret !== 0) begin bad++;
            $display("FAIL post_rst_pulses got=%0d minstret=%0d required 0 0", wcount, minstret); end
    endtask

    task automatic test_random();
        bit   exp_ready, fire;
        ref_t h;
        for (int i = 0; i < 400; i++) begin
            exp_ready = (q.size() < DEPTH);
            commit_stall = ($urandom_range(0, 3) == 0);
            if (exp_ready && $urandom_range(0, 2) != 0)
                send($urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 5) == 0),
                     $urandom_range(0, 3), $urandom_range(0, 1), {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, {$urandom, $urandom});
            #1;
            fire = (q.size() > 0) && !commit_stall;
            total++; if (mem_ready !== exp_ready || commit_valid !== fire) begin bad++;
                $display("FAIL rnd_ctrl i=%0d ready=%b cv=%b required %b %b", i, mem_ready, commit_valid, exp_ready, fire); end
            if (q.size() > 0) begin
                h = q[0];
                total++; if (w_en !== (fire && h.reg_w) || csr_w_en !== (fire && h.is_csr) || reg_writeback_rd !== h.rd) begin bad++;
                    $display("FAIL rnd_wen i=%0d w=%b csr_w=%b rd=%0d required %b %b %0d", i, w_en, csr_w_en, reg_writeback_rd, fire && h.reg_w, fire && h.is_csr, h.rd); end
                total++; if (reg_writeback_data !== h.data || reg_writeback_csr_data_out !== h.csr) begin bad++;
                    $display("FAIL rnd_data i=%0d data=%h csr=%h required %h %h", i, reg_writeback_data, reg_writeback_csr_data_out, h.data, h.csr); end
                total++; if (commit_pc !== h.pc || commit_ins !== h.ins) begin bad++;
                    $display("FAIL rnd_trace i=%0d pc=%h ins=%h required %h %h", i, commit_pc, commit_ins, h.pc, h.ins); end
            end else begin
                total++; if (w_en !== 0 || reg_writeback_data !== 0 || commit_pc !== 0) begin bad++;
                    $display("FAIL rnd_empty i=%0d w=%b data=%h pc=%h required 0", i, w_en, reg_writeback_data, commit_pc); end
            end
            total++; if (minstret !== m_minstret) begin bad++;
                $display("FAIL rnd_minstret i=%0d got=%0d required %0d", i, minstret, m_minstret); end
            tick();
        end
        commit_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_loads();
        test_back_to_back();
        test_x0();
        test_csr();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
